// File: rtl/banked_sum_buffer.sv
// Banked entry buffer with a sequential summation engine.
// Optional BANK_VALID_MASK_EN adds per-entry valid bits and valid_cnt.
module banked_sum_buffer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int SUM_W  = DATA_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_sel,
  input  logic              wr_acc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  input  logic              sum_req,
  output logic              busy,
  output logic              sum_valid,
`ifdef BANK_VALID_MASK_EN
  output logic [IDX_W:0]    valid_cnt,
`endif
  output logic [SUM_W-1:0]  data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  dout_q, dout_d;
  logic [DATA_W-1:0] ent_q [DEPTH];
  logic [DATA_W-1:0] ent_d [DEPTH];
  logic [SUM_W-1:0]  rd_val;

`ifdef BANK_VALID_MASK_EN
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  // Entry/valid next state: clr drops valid only, writes set valid
  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    if (clr) begin
      vld_d = '0;
    end else if (wr_en) begin
      if (wr_acc && vld_q[wr_sel])
        ent_d[wr_sel] = ent_q[wr_sel] + data_in;
      else
        ent_d[wr_sel] = data_in;
      vld_d[wr_sel] = 1'b1;
    end
  end

  // Population count of the next valid vector
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + (IDX_W+1)'(vld_d[i]);
  end

  // Valid bits and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_cnt = cnt_q;
  assign rd_val = vld_q[idx_q] ?
                  {{IDX_W{1'b0}}, ent_q[idx_q]} : '0;
`else
  // Entry next state: clr zeroes all data and beats a write
  always_comb begin
    ent_d = ent_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++)
        ent_d[i] = '0;
    end else if (wr_en) begin
      if (wr_acc)
        ent_d[wr_sel] = ent_q[wr_sel] + data_in;
      else
        ent_d[wr_sel] = data_in;
    end
  end

  assign rd_val = {{IDX_W{1'b0}}, ent_q[idx_q]};
`endif

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  // Summation FSM next state; result latched on the last ACCUM step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (sum_req) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + rd_val;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(DEPTH-1)) begin
          state_d = DONE;
          idx_d   = '0;
          dout_d  = acc_q + rd_val;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, index, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign sum_valid = (state_q == DONE);
  assign data_out  = dout_q;

endmodule

// File: doc/banked_sum_buffer.md
BANKED_SUM_BUFFER -- requirements
Module: banked_sum_buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the entry and data_in width in bits (at least 1).
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count (a power of two, at least 2).
REQ-003 Derived SUM_W = DATA_W + log2(DEPTH); IDX_W = log2(DEPTH).
REQ-004 Clocking SHALL be one clock, clk; reset rst is asynchronous and active-high.
REQ-005 Port list:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- wr_en  in  1  entry write strobe.
- wr_sel  in  IDX_W  target entry index.
- wr_acc  in  1  0 = overwrite; 1 = read-modify-write add.
- data_in  in  DATA_W  write data.
- clr  in  1  clear entries.
- sum_req  in  1  start a summation.
- busy  out  1  summation in progress.
- sum_valid  out  1  one-cycle result strobe.
- data_out  out  SUM_W  last completed sum.

Function
REQ-006 Writes SHALL be accepted in every FSM state: wr_acc=0 gives entry[wr_sel] <= data_in; wr_acc=1 gives entry[wr_sel] <= entry[wr_sel] + data_in, modulo 2^DATA_W.
REQ-007 clr SHALL take one cycle and have priority over wr_en in the same cycle (see REQ-017 for the cleared state).
REQ-008 FSM states SHALL be IDLE, ACCUM and DONE:
- IDLE -> ACCUM on sum_req; this clears the accumulator and sets idx=0.
- ACCUM adds entry[idx] each cycle; after idx=DEPTH-1, go to DONE.
- DONE -> IDLE unconditionally.
REQ-009 sum_req SHALL be ignored outside IDLE; busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-010 sum_valid SHALL be high exactly in DONE: one cycle, DEPTH+1 cycles after the cycle sum_req was sampled in IDLE.
- data_out SHALL update to the final sum in that same cycle and hold until the next completion.
REQ-011 ACCUM SHALL read registered entry values.
- A write in the same cycle as entry[idx] is read does not affect that step.
- Writes to entries not yet read are included; writes to entries already read are not.
REQ-012 clr during ACCUM SHALL not abort the summation; steps after the clr edge read cleared values.
REQ-013 The accumulator SHALL be SUM_W wide and never overflow; the all-ones case is DEPTH*(2^DATA_W-1).
REQ-014 sum_req in the DONE cycle SHALL be ignored; a request is accepted again from the following IDLE cycle.

Reset
REQ-015 rst SHALL asynchronously force:
- FSM to IDLE, idx=0, accumulator=0;
- all entries to 0;
- busy=0, sum_valid=0, data_out=0.
REQ-016 rst mid-ACCUM SHALL abort the summation with no sum_valid pulse; operation resumes on the first clock after rst deasserts.

Configuration
REQ-017 Macro BANK_VALID_MASK_EN SHALL select how clr works and which entries are summed.
- Defined: each entry has a valid bit, set by any write and cleared by rst or clr.
  - clr clears valid bits only; entry data is retained.
  - ACCUM adds 0 for an invalid entry.
  - wr_acc=1 on an invalid entry behaves as an overwrite.
  - An extra output valid_cnt (IDX_W+1 bits, reset 0) SHALL give the number of valid entries, registered.
- Undefined: clr zeroes all entry data; all entries are summed; there is no valid_cnt port.

Verification
REQ-018 Each directed scenario below (DATA_W=8, DEPTH=4) SHALL be covered by the bench:
- Basic sum: write 0x10, 0x20, 0x30, 0x40 to entries 0..3; sum_req in cycle T -> sum_valid in T+5 only, data_out=0x0A0, busy high in T+1..T+5.
- Max width: all entries 0xFF; sum_req -> data_out=0x3FC, with no wrap.
- Accumulate write: entry 2 = 0xF0; wr_acc=1 with data_in 0x20 -> entry 2 = 0x10; the sum includes 0x10.
- Concurrent write: entries all 0x01; sum_req; in the cycle idx=1, write entry 1 = 0x50 and entry 3 = 0x50 -> data_out=0x053.
- Simultaneous clr and wr_en to entry 0 = 0x77 -> entry 0 cleared (data 0 without the macro; invalid with it); a following sum excludes 0x77.
- rst asserted while idx=2 -> no sum_valid pulse, data_out=0, busy=0; a new sum_req after release completes normally.
